// File: rtl/click_decoder.sv
// Groups one-cycle press pulses into single/double/triple-click events and holds
// each event on a valid/ready interface until the consumer takes it.
module click_decoder #(
   parameter int WINDOW    = 25_000_000,
   parameter int WINW      = 25,
   parameter int MAXCLICKS = 3,
   parameter int CW        = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pulse_in,
   input  logic          click_ready,
   output logic          click_valid,
   output logic [CW-1:0] click_count,
   output logic          busy,
   output logic          drop,
   output logic [1:0]    fsm_state
);

   // Handshake: click_valid/click_count are held stable until a cycle with
   // click_valid=1 and click_ready=1; that edge completes the transfer.
   // click_ready while click_valid=0 has no effect.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [WINW-1:0] WIN_LAST = WINW'(WINDOW - 1);
   localparam logic [CW-1:0]   CNT_MAX  = CW'(MAXCLICKS);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

   // A fresh event with a one-click limit is already complete.
   localparam state_t FIRST_STATE = (MAXCLICKS == 1) ? HOLD : COUNT;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [WINW-1:0] timer;
   logic [CW-1:0]   cnt_inc;

   assign cnt_inc = cnt + CNT_ONE;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         timer <= '0;
         drop  <= 1'b0;
      end else begin
         drop <= 1'b0;
         case (state)
            IDLE: begin
               if (pulse_in) begin
                  cnt   <= CNT_ONE;
                  timer <= '0;
                  state <= FIRST_STATE;
               end
            end

            COUNT: begin
               if (pulse_in) begin
                  // A pulse on the last window cycle still extends the event.
                  cnt   <= cnt_inc;
                  timer <= '0;
                  if (cnt_inc == CNT_MAX) begin
                     state <= HOLD;
                  end
               end else if (timer == WIN_LAST) begin
                  timer <= '0;
                  state <= HOLD;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            HOLD: begin
               if (click_ready) begin
                  timer <= '0;
                  if (pulse_in) begin
                     cnt   <= CNT_ONE;
                     state <= FIRST_STATE;
                  end else begin
                     cnt   <= '0;
                     state <= IDLE;
                  end
               end else if (pulse_in) begin
                  drop <= 1'b1;
               end
            end

            default: begin
               state <= IDLE;
               cnt   <= '0;
               timer <= '0;
            end
         endcase
      end
   end

   assign click_valid = (state == HOLD);
   assign click_count = (state == HOLD) ? cnt : '0;
   assign busy        = (state != IDLE);
   assign fsm_state   = state;

endmodule
